// File: rtl/jtag_dr_bank_if.sv
// jtag_dr_bank_if: signals between the TAP controller and the shared DR bank.
//   master: TAP side, drives SEL/CAPTURE_DR/SHIFT_DR/UPDATE_DR/CAPTURE_SEL/STATUS_IN/TDI
//   slave : DR bank, drives TDO/SHADOW/UPDATE_STROBE/LENGTH_ERR
interface jtag_dr_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS = 4
);
    localparam int SEL_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    logic [SEL_WIDTH-1:0] SEL;
    logic CAPTURE_DR;
    logic SHIFT_DR;
    logic UPDATE_DR;
    logic CAPTURE_SEL;
    logic [DATA_WIDTH-1:0] STATUS_IN;
    logic TDI;
    logic TDO;
    logic [NUM_REGS*DATA_WIDTH-1:0] SHADOW;
    logic [NUM_REGS-1:0] UPDATE_STROBE;
    logic LENGTH_ERR;
    modport master (
        output SEL, CAPTURE_DR, SHIFT_DR, UPDATE_DR, CAPTURE_SEL, STATUS_IN, TDI,
        input TDO, SHADOW, UPDATE_STROBE, LENGTH_ERR
    );
    modport slave (
        input SEL, CAPTURE_DR, SHIFT_DR, UPDATE_DR, CAPTURE_SEL, STATUS_IN, TDI,
        output TDO, SHADOW, UPDATE_STROBE, LENGTH_ERR
    );
endinterface

// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: NUM_REGS JTAG data registers sharing one LSB-first shift register.
//   CLOCK_DR : TCK, rising edge
//   RESET    : synchronous, active-high
//   bus      : slave side of jtag_dr_bank_if (capture/shift/update control, TDI/TDO,
//              shadow outputs, per-register update strobe, sticky length error)
module jtag_dr_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS = 4,
    parameter bit CHECK_LENGTH = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input logic CLOCK_DR,
    input logic RESET,
    jtag_dr_bank_if.slave bus
);
    localparam int SEL_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 2);
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] readback;
    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
    logic [SEL_WIDTH-1:0] sel_q;
    logic [CNT_WIDTH-1:0] bit_cnt;
    logic [NUM_REGS-1:0] strobe;
    logic upd_d;
    logic length_err;
    logic fire;
    logic sel_ok;
    logic len_ok;
    // update acts once per rising edge of the UPDATE_DR level
    assign fire = bus.UPDATE_DR && !upd_d;
    assign sel_ok = int'(sel_q) < NUM_REGS;
    assign len_ok = !CHECK_LENGTH || bit_cnt == CNT_WIDTH'(DATA_WIDTH);
    assign bus.TDO = shift_reg[0];
    assign bus.UPDATE_STROBE = strobe;
    assign bus.LENGTH_ERR = length_err;
    // unselectable SEL values read back as zero
    always_comb begin
        readback = '0;
        for (int i = 0; i < NUM_REGS; i++)
            readback = (bus.SEL == SEL_WIDTH'(i)) ? shadow[i] : readback;
    end
    always_comb begin
        bus.SHADOW = '0;
        for (int i = 0; i < NUM_REGS; i++)
            bus.SHADOW[i*DATA_WIDTH +: DATA_WIDTH] = shadow[i];
    end
    // update reads pre-edge shift_reg/bit_cnt/sel_q, so a coincident capture or shift is harmless
    always_ff @(posedge CLOCK_DR) begin
        if (RESET) begin
            shift_reg <= '0;
            sel_q <= '0;
            bit_cnt <= '0;
            upd_d <= 1'b0;
            strobe <= '0;
            length_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                shadow[i] <= RESET_VALUE;
        end else begin
            upd_d <= bus.UPDATE_DR;
            strobe <= '0;
            if (fire && sel_ok)
                length_err <= !len_ok;
            for (int i = 0; i < NUM_REGS; i++)
                if (fire && len_ok && sel_q == SEL_WIDTH'(i)) begin
                    shadow[i] <= shift_reg;
                    strobe[i] <= 1'b1;
                end
            if (bus.CAPTURE_DR) begin
                sel_q <= bus.SEL;
                bit_cnt <= '0;
                shift_reg <= bus.CAPTURE_SEL ? bus.STATUS_IN : readback;
            end else if (bus.SHIFT_DR) begin
                shift_reg <= {bus.TDI, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt <= (bit_cnt == CNT_WIDTH'(DATA_WIDTH + 1)) ? bit_cnt : bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtag_dr_bank.sv
// tb_jtag_dr_bank: directed and randomized transactions against a queue-based model of the DR bank.
module tb_jtag_dr_bank;
    logic CLOCK_DR = 1'b0;
    logic RESET = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] m_shadow [4];
    bit m_q[$];
    int m_cnt;
    int m_sel;
    logic m_err;
    logic [15:0] tdo_seq;
    always #5 CLOCK_DR = ~CLOCK_DR;
    jtag_dr_bank_if #(.DATA_WIDTH(16), .NUM_REGS(4)) bus ();
    jtag_dr_bank #(.DATA_WIDTH(16), .NUM_REGS(4), .CHECK_LENGTH(1), .RESET_VALUE(16'h0000)) dut (
        .CLOCK_DR(CLOCK_DR),
        .RESET(RESET),
        .bus(bus.slave)
    );
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLOCK_DR);
        #1;
    endtask
    function automatic logic [15:0] m_pack();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = m_q[i];
        return r;
    endfunction
    function automatic logic [63:0] m_shadows();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = m_shadow[i];
        return r;
    endfunction
    task automatic m_load(input logic [15:0] v);
        m_q.delete();
        for (int i = 0; i < 16; i++) m_q.push_back(v[i]);
    endtask
    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 16'h0000;
        m_load(16'h0000);
        m_cnt = 0;
        m_sel = 0;
        m_err = 1'b0;
        check("reset_tdo", 64'(bus.TDO), 64'(0));
        check("reset_shadow", bus.SHADOW, m_shadows());
        check("reset_strobe", 64'(bus.UPDATE_STROBE), 64'(0));
        check("reset_err", 64'(bus.LENGTH_ERR), 64'(0));
    endtask
    task automatic do_capture(input int sel, input logic csel, input logic [15:0] status);
        bus.SEL = 2'(sel);
        bus.CAPTURE_SEL = csel;
        bus.STATUS_IN = status;
        bus.CAPTURE_DR = 1'b1;
        tick();
        bus.CAPTURE_DR = 1'b0;
        m_load(csel ? status : m_shadow[sel]);
        m_cnt = 0;
        m_sel = sel;
        check("capture_tdo", 64'(bus.TDO), 64'(m_q[0]));
        check("capture_err_kept", 64'(bus.LENGTH_ERR), 64'(m_err));
    endtask
    // SEL is scrambled on every shift bit: only the captured selection may matter
    task automatic do_shift(input int n, input logic [31:0] data);
        for (int i = 0; i < n; i++) begin
            if (i < 16) tdo_seq[i] = bus.TDO;
            bus.TDI = data[i];
            bus.SHIFT_DR = 1'b1;
            bus.SEL = 2'($urandom_range(0, 3));
            tick();
            void'(m_q.pop_front());
            m_q.push_back(data[i]);
            m_cnt++;
            check("shift_tdo", 64'(bus.TDO), 64'(m_q[0]));
        end
        bus.SHIFT_DR = 1'b0;
        bus.TDI = 1'b0;
    endtask
    task automatic do_update(input int hold);
        logic [3:0] exp_strobe;
        exp_strobe = 4'b0000;
        if (m_sel < 4 && m_cnt == 16) begin
            m_shadow[m_sel] = m_pack();
            exp_strobe[m_sel] = 1'b1;
            m_err = 1'b0;
        end else if (m_sel < 4) begin
            m_err = 1'b1;
        end
        bus.UPDATE_DR = 1'b1;
        tick();
        check("update_strobe", 64'(bus.UPDATE_STROBE), 64'(exp_strobe));
        check("update_shadow", bus.SHADOW, m_shadows());
        check("update_err", 64'(bus.LENGTH_ERR), 64'(m_err));
        for (int i = 1; i < hold; i++) begin
            tick();
            check("hold_strobe", 64'(bus.UPDATE_STROBE), 64'(0));
        end
        bus.UPDATE_DR = 1'b0;
        tick();
        check("post_strobe", 64'(bus.UPDATE_STROBE), 64'(0));
        check("post_shadow", bus.SHADOW, m_shadows());
    endtask
    initial begin
        int lens[6] = '{16, 16, 15, 17, 16, 20};
        bus.SEL = '0;
        bus.CAPTURE_DR = 1'b0;
        bus.SHIFT_DR = 1'b0;
        bus.UPDATE_DR = 1'b0;
        bus.CAPTURE_SEL = 1'b0;
        bus.STATUS_IN = '0;
        bus.TDI = 1'b0;
        tick();
        do_reset();
        tick();
        check("idle_shadow", bus.SHADOW, 64'(0));
        do_capture(2, 1'b0, 16'hFFFF);
        do_shift(16, 32'hA5C3);
        do_update(1);
        check("a5c3_value", 64'(bus.SHADOW[47:32]), 64'(16'hA5C3));
        check("a5c3_others", {bus.SHADOW[63:48], bus.SHADOW[31:0]}, 64'(0));
        do_capture(0, 1'b1, 16'h1234);
        do_shift(16, 32'h0);
        check("status_tdo_seq", 64'(tdo_seq), 64'(16'h1234));
        do_capture(1, 1'b0, 16'h0);
        do_shift(15, 32'h7ABC);
        do_update(1);
        check("short_err", 64'(bus.LENGTH_ERR), 64'(1));
        do_capture(1, 1'b0, 16'h0);
        do_shift(16, 32'h5EED);
        do_update(1);
        check("good_err", 64'(bus.LENGTH_ERR), 64'(0));
        do_capture(3, 1'b0, 16'h0);
        do_shift(16, 32'hC0DE);
        do_update(3);
        do_capture(2, 1'b0, 16'h0);
        do_shift(8, 32'h00FF);
        do_reset();
        do_update(1);
        check("reset_then_update_err", 64'(bus.LENGTH_ERR), 64'(1));
        for (int t = 0; t < 40; t++) begin
            do_capture(int'($urandom_range(0, 3)), 1'($urandom), 16'($urandom));
            do_shift(lens[$urandom_range(0, 5)], $urandom);
            if ($urandom_range(0, 9) == 0) do_reset();
            do_update(int'($urandom_range(1, 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
